// File: rtl/pll_reconfig_if.sv
// pll_reconfig_if: request handshake, status and Avalon-MM management signals of the PLL reconfig sequencer.
interface pll_reconfig_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [8:0]  cfg_n;
  logic [8:0]  cfg_m;
  logic [31:0] cfg_k;
  logic [8:0]  cfg_c;
  logic        done;
  logic        err;
  logic        busy;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  modport master (
    input  cfg_valid, cfg_n, cfg_m, cfg_k, cfg_c, pll_locked, mgmt_readdata, mgmt_waitrequest,
    output cfg_ready, done, err, busy, mgmt_address, mgmt_write, mgmt_read, mgmt_writedata
  );
  modport slave (
    output cfg_valid, cfg_n, cfg_m, cfg_k, cfg_c, pll_locked, mgmt_readdata, mgmt_waitrequest,
    input  cfg_ready, done, err, busy, mgmt_address, mgmt_write, mgmt_read, mgmt_writedata
  );
endinterface

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: writes one N/M/K/C divider set to the PLL reconfig IP, starts it and waits for lock.
// Define PLLRC_POLL_MODE_EN to use polling mode (status register reads) instead of waitrequest mode.
module pll_reconfig_sequencer #(
  parameter int C_SEL        = 0,
  parameter int LOCK_BLANK   = 16,
  parameter int LOCK_TIMEOUT = 100000
) (
  input logic            mgmt_clk,
  input logic            mgmt_rst_n,
  pll_reconfig_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, WR_M, WR_K, WR_C, WR_START,
`ifdef PLLRC_POLL_MODE_EN
    RD_STATUS,
`endif
    BLANK, WAIT_LOCK, DONE
  } state_t;
`ifdef PLLRC_POLL_MODE_EN
  localparam state_t      AFTER_START = RD_STATUS;
  localparam logic [31:0] MODE        = 32'd1;
`else
  localparam state_t      AFTER_START = BLANK;
  localparam logic [31:0] MODE        = 32'd0;
`endif
  state_t      state, nxt;
  logic [8:0]  n_r, m_r, c_r;
  logic [31:0] k_r, cnt;
  logic [1:0]  lk;
  logic        live, err_r, bad, go, accept, timeout;
  // hi/lo counter halves; truncation to 8 bits makes 256 encode as 0, bypass forces hi=lo=1
  function automatic logic [17:0] enc(input logic [8:0] d);
    logic [9:0] hi;
    hi = (10'(d) + 10'd1) >> 1;
    return (d == 9'd1) ? 18'h20101 : {1'b0, d[0], hi[7:0], d[8:1]};
  endfunction
  assign bad           = ~|n_r | ~|m_r | ~|c_r;
  assign go            = !bus.mgmt_waitrequest;
  assign timeout       = cnt == 32'(LOCK_TIMEOUT - 1);
  assign bus.cfg_ready = live && state == IDLE;
  assign accept        = bus.cfg_valid && bus.cfg_ready;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.err       = err_r;
  always_comb begin
    nxt                = state;
    bus.mgmt_write     = 1'b0;
    bus.mgmt_read      = 1'b0;
    bus.mgmt_address   = 6'd0;
    bus.mgmt_writedata = 32'd0;
    case (state)
      IDLE: nxt = accept ? WR_MODE : IDLE;
      WR_MODE: begin
        bus.mgmt_write     = !bad;
        bus.mgmt_writedata = MODE;
        nxt                = bad ? DONE : (go ? WR_N : WR_MODE);
      end
      WR_N: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h03;
        bus.mgmt_writedata = {14'd0, enc(n_r)};
        nxt                = go ? WR_M : WR_N;
      end
      WR_M: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h04;
        bus.mgmt_writedata = {14'd0, enc(m_r)};
        nxt                = go ? WR_K : WR_M;
      end
      WR_K: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h07;
        bus.mgmt_writedata = k_r;
        nxt                = go ? WR_C : WR_K;
      end
      WR_C: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h05;
        bus.mgmt_writedata = {9'd0, 5'(C_SEL), enc(c_r)};
        nxt                = go ? WR_START : WR_C;
      end
      WR_START: begin
        bus.mgmt_write     = 1'b1;
        bus.mgmt_address   = 6'h02;
        bus.mgmt_writedata = 32'd1;
        nxt                = go ? AFTER_START : WR_START;
      end
`ifdef PLLRC_POLL_MODE_EN
      RD_STATUS: begin
        bus.mgmt_read    = 1'b1;
        bus.mgmt_address = 6'h01;
        nxt              = (go && bus.mgmt_readdata[0]) ? BLANK : (timeout ? DONE : RD_STATUS);
      end
`endif
      BLANK:     nxt = (cnt == 32'(LOCK_BLANK - 1)) ? WAIT_LOCK : BLANK;
      WAIT_LOCK: nxt = (lk[1] || timeout) ? DONE : WAIT_LOCK;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge mgmt_clk or negedge mgmt_rst_n) begin
    if (!mgmt_rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
      err_r <= 1'b0;
      cnt   <= 32'd0;
      lk    <= 2'b00;
      n_r   <= 9'd0;
      m_r   <= 9'd0;
      c_r   <= 9'd0;
      k_r   <= 32'd0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
      lk    <= {lk[0], bus.pll_locked};
      cnt   <= (nxt != state) ? 32'd0 : cnt + 32'd1;
      if (accept) begin
        n_r   <= bus.cfg_n;
        m_r   <= bus.cfg_m;
        c_r   <= bus.cfg_c;
        k_r   <= bus.cfg_k;
        err_r <= 1'b0;
      end else if (nxt == DONE && state != DONE)
        err_r <= state != WAIT_LOCK || !lk[1];
    end
  end
endmodule
